tl_sensor_cond: RTL and testbench



---
 rtl/tl_sensor_cond.sv | 122 ++++++++++++
 tb/tb_tl_sensor_cond.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: input conditioning for the left-turn traffic light controller.
// Four raw vehicle detectors are synchronised and debounced. A detection is then
// held as a pending request until the matching movement is shown its light, or
// until it has waited HOLD_MAX cycles with no vehicle present.
// Channel order inside the block: 0 = A through, 1 = A left, 2 = B through, 3 = B left.
module tl_sensor_cond #(
    parameter int DB_CYCLES = 3,    // 1..15
    parameter int HOLD_MAX  = 200   // 1..255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       det_a,
    input  logic       det_al,
    input  logic       det_b,
    input  logic       det_bl,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    output logic       Ta,
    output logic       Tal,
    output logic       Tb,
    output logic       Tbl
);

    // Light codes shared with the controller
    localparam logic [1:0] LIGHT_GREEN = 2'b00;
    localparam logic [1:0] LIGHT_LEFT  = 2'b11;

    localparam logic [3:0] DC_LAST = 4'(DB_CYCLES - 1);
    localparam logic [7:0] HC_LAST = 8'(HOLD_MAX - 1);

    logic [3:0] det;
    logic [3:0] serve;
    logic [3:0] t;

    assign det   = {det_bl, det_b, det_al, det_a};
    // A channel is served while the controller shows it its own green or arrow
    assign serve = {Lb == LIGHT_LEFT, Lb == LIGHT_GREEN,
                    La == LIGHT_LEFT, La == LIGHT_GREEN};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic       s1_reg;
            logic       s2_reg;
            logic       db_reg;
            logic       db_next;
            logic [3:0] dc_reg;
            logic       lat_reg;
            logic [7:0] hc_reg;
            logic       rise;
            logic       hold_run;
            logic       timeout;

            // Two-flop synchroniser for the asynchronous detector
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= det[gi];
                    s2_reg <= s1_reg;
                end
            end

            // Accept the new level once it has differed from db for DB_CYCLES samples
            always_comb begin
                db_next = db_reg;
                if ((s2_reg != db_reg) && (dc_reg == DC_LAST))
                    db_next = s2_reg;
            end

            // Debounce counter; any sample equal to db restarts the count
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    db_reg <= 1'b0;
                    dc_reg <= 4'd0;
                end else if (s2_reg == db_reg) begin
                    dc_reg <= 4'd0;
                end else if (dc_reg == DC_LAST) begin
                    db_reg <= s2_reg;
                    dc_reg <= 4'd0;
                end else begin
                    dc_reg <= dc_reg + 4'd1;
                end
            end

            assign rise     = db_next & ~db_reg;
            assign hold_run = lat_reg & ~db_reg;
            assign timeout  = hold_run & (hc_reg == HC_LAST);

            // Stale-request timer runs only while a request waits with no vehicle
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    hc_reg <= 8'd0;
                else if (!hold_run || timeout)
                    hc_reg <= 8'd0;
                else
                    hc_reg <= hc_reg + 8'd1;
            end

            // Pending request: serving beats a new detection, which beats the timeout
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    lat_reg <= 1'b0;
                else if (serve[gi])
                    lat_reg <= 1'b0;
                else if (rise)
                    lat_reg <= 1'b1;
                else if (timeout)
                    lat_reg <= 1'b0;
            end

            // Both terms are flops, so the request level is glitch-free
            assign t[gi] = db_reg | lat_reg;
        end
    endgenerate

    assign Ta  = t[0];
    assign Tal = t[1];
    assign Tb  = t[2];
    assign Tbl = t[3];

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: two instances (HOLD_MAX 200 and 4) share the stimulus.
// A window-based reference model is compared on every falling edge, and directed
// literal expectations pin the key latencies.
module tb_tl_sensor_cond;

    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       det_a = 1'b0, det_al = 1'b0, det_b = 1'b0, det_bl = 1'b0;
    logic [1:0] La = 2'b10, Lb = 2'b10;
    logic       Ta0, Tal0, Tb0, Tbl0;
    logic       Ta1, Tal1, Tb1, Tbl1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_sensor_cond #(.DB_CYCLES(DB), .HOLD_MAX(200)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .det_a(det_a), .det_al(det_al), .det_b(det_b), .det_bl(det_bl),
        .La(La), .Lb(Lb),
        .Ta(Ta0), .Tal(Tal0), .Tb(Tb0), .Tbl(Tbl0)
    );

    tl_sensor_cond #(.DB_CYCLES(DB), .HOLD_MAX(4)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .det_a(det_a), .det_al(det_al), .det_b(det_b), .det_bl(det_bl),
        .La(La), .Lb(Lb),
        .Ta(Ta1), .Tal(Tal1), .Tb(Tb1), .Tbl(Tbl1)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Debounced level flips when the last DB synchronised samples all disagree with it.
    // A request stays pending until served, or until HOLD cycles pass with no vehicle.
    int  hold_of[2] = '{200, 4};
    bit  s1m[2][4], s2m[2][4], dbm[2][4], latm[2][4];
    bit  win[2][4][DB];
    int  idle[2][4];

    function automatic bit served(input int c);
        case (c)
            0: return La == 2'b00;
            1: return La == 2'b11;
            2: return Lb == 2'b00;
            default: return Lb == 2'b11;
        endcase
    endfunction

    function automatic bit det_of(input int c);
        case (c)
            0: return det_a;
            1: return det_al;
            2: return det_b;
            default: return det_bl;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                s1m[i][c] = 0; s2m[i][c] = 0; dbm[i][c] = 0; latm[i][c] = 0;
                idle[i][c] = 0;
                for (int w = 0; w < DB; w++) win[i][c][w] = 0;
            end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                bit all_diff, db_new, rise, tout, lat_new;
                for (int w = DB - 1; w > 0; w--) win[i][c][w] = win[i][c][w-1];
                win[i][c][0] = s2m[i][c];
                all_diff = 1;
                for (int w = 0; w < DB; w++)
                    if (win[i][c][w] == dbm[i][c]) all_diff = 0;
                db_new = all_diff ? !dbm[i][c] : dbm[i][c];
                rise = db_new && !dbm[i][c];
                idle[i][c] = (latm[i][c] && !dbm[i][c]) ? idle[i][c] + 1 : 0;
                tout = (idle[i][c] == hold_of[i]);
                if (tout) idle[i][c] = 0;
                if (served(c))  lat_new = 0;
                else if (rise)  lat_new = 1;
                else if (tout)  lat_new = 0;
                else            lat_new = latm[i][c];
                dbm[i][c]  = db_new;
                latm[i][c] = lat_new;
                s2m[i][c]  = s1m[i][c];
                s1m[i][c]  = det_of(c);
            end
    endtask

    // Model update: follows the DUT's clock and asynchronous reset
    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else          model_step();
        end
    end

    // Per-cycle comparison of all eight outputs against the model
    initial begin
        logic [3:0] got0, got1;
        forever begin
            @(negedge clk);
            got0 = {Tbl0, Tb0, Tal0, Ta0};
            got1 = {Tbl1, Tb1, Tal1, Ta1};
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("model_h200_ch%0d", c), got0[c], dbm[0][c] | latm[0][c]);
                chk($sformatf("model_h4_ch%0d", c),   got1[c], dbm[1][c] | latm[1][c]);
            end
        end
    end

    // Drop every pending request: detectors quiet, then show each movement its light
    task automatic clear_all();
        det_a = 0; det_al = 0; det_b = 0; det_bl = 0;
        tick(8);
        La = 2'b00; Lb = 2'b00; tick(1);
        La = 2'b11; Lb = 2'b11; tick(1);
        La = 2'b10; Lb = 2'b10; tick(1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // 1: reset hold, outputs low during and after
        #11;
        chk("rst_Ta", Ta0, 1'b0);  chk("rst_Tal", Tal0, 1'b0);
        chk("rst_Tb", Tb0, 1'b0);  chk("rst_Tbl", Tbl0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);
        chk("post_rst_Ta", Ta0, 1'b0); chk("post_rst_Tbl", Tbl0, 1'b0);

        // 2: det_a held -> Ta rises after edge k+4
        det_a = 1; tick(4);
        chk("a_rise_k3", Ta0, 1'b0);
        tick(1);
        chk("a_rise_k4", Ta0, 1'b1);
        tick(3);
        chk("a_held", Ta0, 1'b1);
        clear_all();
        chk("a_cleared", Ta0, 1'b0);

        // 3: det_al bounce 1-0-1-0 never qualifies
        det_al = 1; tick(1); det_al = 0; tick(1);
        det_al = 1; tick(1); det_al = 0; tick(10);
        chk("al_bounce_h200", Tal0, 1'b0);
        chk("al_bounce_h4", Tal1, 1'b0);

        // 4: det_b 6 cycles, latched, yellow ignored, green clears
        det_b = 1; tick(4);
        chk("b_rise_k3", Tb0, 1'b0);
        tick(1);
        chk("b_rise_k4", Tb0, 1'b1);
        tick(1);
        det_b = 0; tick(10);
        chk("b_latched", Tb0, 1'b1);
        Lb = 2'b01; tick(1); Lb = 2'b10;
        chk("b_yellow_keeps", Tb0, 1'b1);
        Lb = 2'b00; tick(1); Lb = 2'b10;
        chk("b_green_clears", Tb0, 1'b0);
        chk("b_green_clears_h4", Tb1, 1'b0);
        tick(2);

        // 5: det_bl 5-cycle pulse, timeout after 4 / 200 idle cycles
        det_bl = 1; tick(5);
        det_bl = 0; tick(8);
        chk("bl_h4_before", Tbl1, 1'b1);
        tick(1);
        chk("bl_h4_drop", Tbl1, 1'b0);
        chk("bl_h200_hold", Tbl0, 1'b1);
        tick(195);
        chk("bl_h200_last", Tbl0, 1'b1);
        tick(1);
        chk("bl_h200_drop", Tbl0, 1'b0);
        tick(2);

        // 6a: served at db rise -> no latch, Ta follows db only
        La = 2'b00; det_a = 1; tick(4);
        chk("a_srv_k3", Ta0, 1'b0);
        tick(1);
        chk("a_srv_k4", Ta0, 1'b1);
        La = 2'b10; tick(2);
        chk("a_srv_db", Ta0, 1'b1);
        det_a = 0; tick(4);
        chk("a_fall_m3", Ta0, 1'b1);
        tick(1);
        chk("a_fall_m4", Ta0, 1'b0);

        // 6b: asynchronous reset mid-pulse, then full re-qualification
        det_al = 1; tick(6);
        chk("al_up", Tal0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("al_async_rst", Tal0, 1'b0);
        chk("al_async_rst_h4", Tal1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(4);
        chk("al_requal_j3", Tal0, 1'b0);
        tick(1);
        chk("al_requal_j4", Tal0, 1'b1);
        det_al = 0; tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
